// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first, idle-high line. The serial
//                input is resynchronised, the start bit is validated at its
//                midpoint, and data/stop bits are sampled once per bit period
//                at the same phase. The bit period is latched at frame start.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [15:0] i_Clocks_per_Bit,
  input  logic        i_Rx_Serial,
  output logic        o_Rx_DV,
  output logic [7:0]  o_Rx_Byte,
  output logic        o_Rx_Active,
  output logic        o_Frame_Err,
  output logic [7:0]  o_debug
);

  // Smallest bit period that still leaves a distinct mid-bit sample point.
  localparam logic [15:0] c_MIN_CPB = 16'd2;
  localparam logic [2:0]  c_LAST_BIT = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_clk_count;
  logic [2:0]  r_bit_index;
  logic [7:0]  r_shift;
  logic [15:0] r_CPB;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_sync;
  logic [15:0]            w_cpb_clamped;
  logic [15:0]            w_half_count;
  logic [15:0]            w_last_count;

  // --------------------------------------------------------------------------
  // Input synchroniser: a chain of SYNC_STAGES flops, reset to the idle level
  // so a reset never looks like a start edge.
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
      if (g == 0) begin : g_first
        // First stage samples the raw asynchronous line.
        always_ff @(posedge i_Clock or negedge i_Reset_n) begin
          if (!i_Reset_n) r_sync[0] <= 1'b1;
          else            r_sync[0] <= i_Rx_Serial;
        end
      end else begin : g_rest
        // Later stages resolve metastability of the previous stage.
        always_ff @(posedge i_Clock or negedge i_Reset_n) begin
          if (!i_Reset_n) r_sync[g] <= 1'b1;
          else            r_sync[g] <= r_sync[g-1];
        end
      end
    end
  endgenerate

  assign w_rx_sync = r_sync[SYNC_STAGES-1];

  // Bit periods below two cycles cannot be centred; treat them as two.
  assign w_cpb_clamped = (i_Clocks_per_Bit < c_MIN_CPB) ? c_MIN_CPB : i_Clocks_per_Bit;

  // Sample points derived from the period latched for the current frame.
  assign w_half_count = (r_CPB - 16'd1) >> 1;
  assign w_last_count = r_CPB - 16'd1;

  // --------------------------------------------------------------------------
  // Receive state machine with registered strobes and status.
  // The counter only ever runs up to r_CPB-1, so it cannot wrap in a bit.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state     <= IDLE;
      r_clk_count <= 16'd0;
      r_bit_index <= 3'd0;
      r_shift     <= 8'h00;
      r_CPB       <= c_MIN_CPB;
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Rx_Active <= 1'b0;
      o_Rx_Byte   <= 8'h00;
    end else begin
      // Strobes are one cycle wide: cleared unless re-asserted below.
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;

      case (r_state)
        IDLE: begin
          r_clk_count <= 16'd0;
          r_bit_index <= 3'd0;
          if (!w_rx_sync) begin
            // Freeze the bit period so mid-frame changes cannot skew sampling.
            r_CPB       <= w_cpb_clamped;
            o_Rx_Active <= 1'b1;
            r_state     <= START;
          end
        end

        START: begin
          if (r_clk_count == w_half_count) begin
            if (!w_rx_sync) begin
              // Genuine start bit: re-zero so data samples land mid-bit.
              r_clk_count <= 16'd0;
              r_state     <= DATA;
            end else begin
              // Line went back high before mid-bit: a glitch, not a frame.
              r_clk_count <= 16'd0;
              o_Rx_Active <= 1'b0;
              r_state     <= IDLE;
            end
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end

        DATA: begin
          if (r_clk_count == w_last_count) begin
            r_shift[r_bit_index] <= w_rx_sync;
            r_clk_count          <= 16'd0;
            if (r_bit_index == c_LAST_BIT) begin
              r_bit_index <= 3'd0;
              r_state     <= STOP;
            end else begin
              r_bit_index <= r_bit_index + 3'd1;
            end
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end

        STOP: begin
          if (r_clk_count == w_last_count) begin
            r_clk_count <= 16'd0;
            if (w_rx_sync) begin
              o_Rx_Byte <= r_shift;
              o_Rx_DV   <= 1'b1;
            end else begin
              // Bad stop bit: report it and keep the last good byte.
              o_Frame_Err <= 1'b1;
            end
            r_state <= CLEANUP;
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end

        CLEANUP: begin
          // Hold here while the line is low so a break is not seen as a start.
          if (w_rx_sync) begin
            o_Rx_Active <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          // Unreachable encodings recover to a clean idle.
          r_clk_count <= 16'd0;
          r_bit_index <= 3'd0;
          o_Rx_Active <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_debug = {o_Rx_DV, o_Frame_Err, o_Rx_Active, w_rx_sync, 1'b0, r_state};

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx using a table of single
//                frames plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpb_in;
  logic        rx;
  logic        dv;
  logic [7:0]  rx_byte;
  logic        active;
  logic        ferr;
  logic [7:0]  dbg;

  int checks = 0;
  int errors = 0;

  int dv_total   = 0;
  int fe_total   = 0;
  int both_total = 0;
  int cyc        = 0;
  int dv_cycle   = 0;
  int start_cyc  = 0;
  logic [7:0] byte_log [0:63];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .i_Clock          (clk),
    .i_Reset_n        (rst_n),
    .i_Clocks_per_Bit (cpb_in),
    .i_Rx_Serial      (rx),
    .o_Rx_DV          (dv),
    .o_Rx_Byte        (rx_byte),
    .o_Rx_Active      (active),
    .o_Frame_Err      (ferr),
    .o_debug          (dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Observe strobes away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dv) begin
        byte_log[dv_total % 64] = rx_byte;
        dv_cycle = cyc;
        dv_total = dv_total + 1;
      end
      if (ferr) fe_total = fe_total + 1;
      if (dv && ferr) both_total = both_total + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    step(n);
  endtask

  // Drive one 8N1 frame; caller is positioned just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
    logic [9:0] fr;
    int eff;
    eff = (cpb < 2) ? 2 : cpb;
    fr  = {stop_bit, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rx = fr[j];
      if (j == 0) start_cyc = cyc;
      step(eff);
    end
  endtask

  typedef struct {
    int         cpb;
    logic [7:0] data;
    logic       stop_bit;
    int         exp_dv;
    logic [7:0] exp_byte;
    int         exp_fe;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    int dv0, fe0, lat, t, eff;

    vecs[0] = '{cpb: 10, data: 8'hA5, stop_bit: 1'b1, exp_dv: 1, exp_byte: 8'hA5, exp_fe: 0};
    vecs[1] = '{cpb: 0,  data: 8'h5A, stop_bit: 1'b1, exp_dv: 1, exp_byte: 8'h5A, exp_fe: 0};
    vecs[2] = '{cpb: 1,  data: 8'hC7, stop_bit: 1'b1, exp_dv: 1, exp_byte: 8'hC7, exp_fe: 0};
    vecs[3] = '{cpb: 2,  data: 8'h01, stop_bit: 1'b1, exp_dv: 1, exp_byte: 8'h01, exp_fe: 0};
    vecs[4] = '{cpb: 16, data: 8'hE4, stop_bit: 1'b1, exp_dv: 1, exp_byte: 8'hE4, exp_fe: 0};
    vecs[5] = '{cpb: 7,  data: 8'h99, stop_bit: 1'b0, exp_dv: 0, exp_byte: 8'hE4, exp_fe: 1};

    rst_n  = 1'b0;
    rx     = 1'b1;
    cpb_in = 16'd10;
    repeat (3) @(posedge clk);
    #1;

    // Reset state: synchroniser at 1, everything else cleared.
    check("reset_byte",   rx_byte, 8'h00);
    check("reset_dv",     dv,      1'b0);
    check("reset_fe",     ferr,    1'b0);
    check("reset_active", active,  1'b0);
    check("reset_debug",  dbg,     8'b0001_0000);

    rst_n = 1'b1;
    step(5);

    // Table of single frames at various bit periods.
    for (int i = 0; i < 6; i++) begin
      cpb_in = vecs[i].cpb[15:0];
      eff    = (vecs[i].cpb < 2) ? 2 : vecs[i].cpb;
      idle(4);
      dv0 = dv_total;
      fe0 = fe_total;
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].cpb);
      idle(3 * eff + 10);
      check($sformatf("vec%0d_dv_count", i), dv_total - dv0, vecs[i].exp_dv);
      check($sformatf("vec%0d_byte", i),     rx_byte,        vecs[i].exp_byte);
      check($sformatf("vec%0d_fe_count", i), fe_total - fe0, vecs[i].exp_fe);
    end

    // Latency from line falling edge to DV at CPB=10: 2 + 4 + 90 + 2.
    cpb_in = 16'd10;
    idle(5);
    dv0 = dv_total;
    send_frame(8'hA5, 1'b1, 10);
    idle(20);
    lat = dv_cycle - start_cyc;
    check("lat_dv_count", dv_total - dv0, 1);
    check_range("lat_cycles", lat, 97, 99);

    // Back-to-back frames with no idle gap.
    dv0 = dv_total;
    send_frame(8'h3C, 1'b1, 10);
    send_frame(8'hC3, 1'b1, 10);
    idle(30);
    check("b2b_dv_count", dv_total - dv0, 2);
    check("b2b_first",    byte_log[dv0 % 64],       8'h3C);
    check("b2b_second",   byte_log[(dv0 + 1) % 64], 8'hC3);

    // Three-cycle glitch on an idle line.
    dv0 = dv_total;
    fe0 = fe_total;
    rx  = 1'b0;
    step(3);
    rx  = 1'b1;
    check("glitch_engaged", active, 1'b1);
    t = 0;
    while (active && t < 12) begin
      step(1);
      t = t + 1;
    end
    check_range("glitch_active_drop", t, 1, 8);
    idle(20);
    check("glitch_dv", dv_total - dv0, 0);
    check("glitch_fe", fe_total - fe0, 0);
    check("glitch_state", dbg[2:0], 3'd0);

    // Bad stop bit followed by a held-low line.
    dv0 = dv_total;
    fe0 = fe_total;
    send_frame(8'h55, 1'b0, 10);
    step(30);
    check("ferr_count",   fe_total - fe0, 1);
    check("ferr_no_dv",   dv_total - dv0, 0);
    check("ferr_keep",    rx_byte,  8'hC3);
    check("ferr_cleanup", dbg[2:0], 3'd4);
    check("ferr_active",  active,   1'b1);
    idle(5);
    check("ferr_exit_state",  dbg[2:0], 3'd0);
    check("ferr_exit_active", active,   1'b0);
    dv0 = dv_total;
    send_frame(8'h81, 1'b1, 10);
    idle(20);
    check("after_ferr_dv",   dv_total - dv0, 1);
    check("after_ferr_byte", rx_byte, 8'h81);

    // Reset in the middle of the data bits of 0xFF.
    dv0 = dv_total;
    fe0 = fe_total;
    rx  = 1'b0;
    step(10);
    rx  = 1'b1;
    step(25);
    check("rst_mid_in_data", dbg[2:0], 3'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_byte",   rx_byte,  8'h00);
    check("rst_mid_active", active,   1'b0);
    check("rst_mid_state",  dbg[2:0], 3'd0);
    step(3);
    rst_n = 1'b1;
    idle(100);
    check("rst_abort_dv", dv_total - dv0, 0);
    check("rst_abort_fe", fe_total - fe0, 0);
    send_frame(8'h12, 1'b1, 10);
    idle(20);
    check("rst_then_dv",   dv_total - dv0, 1);
    check("rst_then_byte", rx_byte, 8'h12);

    // Bit period changed mid-frame: current frame stays at CPB=10.
    cpb_in = 16'd10;
    dv0 = dv_total;
    fork
      send_frame(8'h6B, 1'b1, 10);
      begin
        repeat (30) @(posedge clk);
        #2;
        cpb_in = 16'd20;
      end
    join
    idle(30);
    check("cpb_change_dv",   dv_total - dv0, 1);
    check("cpb_change_byte", rx_byte, 8'h6B);
    dv0 = dv_total;
    send_frame(8'h2D, 1'b1, 20);
    idle(50);
    check("cpb20_dv",   dv_total - dv0, 1);
    check("cpb20_byte", rx_byte, 8'h2D);

    check("dv_fe_never_together", both_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flops in the i_Rx_Serial synchronizer (legal values 2..4).
REQ-002 SHALL have port i_Clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port i_Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_Clocks_per_Bit, input, 16 bits: bit period in i_Clock cycles (CPB).
REQ-005 SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port o_Rx_DV, output, 1 bit: one-cycle strobe, byte valid.
REQ-007 SHALL have port o_Rx_Byte, output, 8 bits: last good received byte.
REQ-008 SHALL have port o_Rx_Active, output, 1 bit: frame in progress.
REQ-009 SHALL have port o_Frame_Err, output, 1 bit: one-cycle strobe, stop bit sampled low.
REQ-010 SHALL have port o_debug, output, 8 bits: {o_Rx_DV, o_Frame_Err, o_Rx_Active, rx_sync, 1'b0, state[2:0]}.

Function
REQ-011 SHALL pass i_Rx_Serial through SYNC_STAGES flops (reset value 1); rx_sync is the last stage, and all decisions use rx_sync only.
REQ-012 SHALL implement states IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4; any other encoding SHALL return to IDLE on the next cycle.
REQ-013 IDLE: clock counter=0 and bit index=0; on rx_sync==0 the block SHALL latch CPB into an internal 16-bit register r_CPB, set o_Rx_Active=1, and go to START.
REQ-014 r_CPB SHALL be max(i_Clocks_per_Bit, 2); changes to i_Clocks_per_Bit mid-frame SHALL have no effect until the next frame.
REQ-015 START: count up to (r_CPB-1)>>1 (mid start bit); at that count, if rx_sync==0 the block SHALL clear the counter and go to DATA, else it SHALL treat the event as a glitch, clear o_Rx_Active, and go to IDLE with no strobe.
REQ-016 DATA: count 0..r_CPB-1; at count r_CPB-1 the block SHALL store rx_sync into shift bit [index], clear the counter, and increment the index; after index 7 it SHALL go to STOP with index wrapped to 0.
REQ-017 STOP: at count r_CPB-1 the block SHALL sample rx_sync; if 1, o_Rx_Byte SHALL load the shift register and o_Rx_DV SHALL pulse; if 0, o_Frame_Err SHALL pulse and o_Rx_Byte SHALL be unchanged; in both cases the block SHALL go to CLEANUP.
REQ-018 o_Rx_DV and o_Frame_Err SHALL be registered, high for exactly one cycle (the cycle CLEANUP is entered), and never high together.
REQ-019 CLEANUP: the block SHALL remain until rx_sync==1 (guards against break/low line retriggering), then clear o_Rx_Active and go to IDLE; a high line SHALL give a one-cycle stay.
REQ-020 o_Rx_Active SHALL be high from the cycle after the start edge is detected until CLEANUP exits.
REQ-021 Latency: o_Rx_DV SHALL rise SYNC_STAGES + (r_CPB-1)>>1 + 9*r_CPB + 2 cycles (±1 for edge phase) after the i_Rx_Serial falling edge.
REQ-022 A new start bit arriving immediately after the stop bit (back-to-back frames) SHALL be received without loss.
REQ-023 The clock counter SHALL be 16 bits and SHALL never wrap within a bit period.

Reset
REQ-024 On i_Reset_n low, asynchronously: state=IDLE, counters=0, o_Rx_DV=0, o_Frame_Err=0, o_Rx_Active=0, o_Rx_Byte=8'h00, synchronizer=all 1s.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no strobe; after release the block SHALL wait for a fresh falling edge.

Verification
REQ-026 CPB=10, send 0xA5 8N1 -> exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Frame_Err never high.
REQ-027 CPB=10, send 0x3C then 0xC3 back-to-back with no idle gap -> two DV pulses, bytes 0x3C then 0xC3.
REQ-028 CPB=10, 3-cycle low glitch on an idle line -> no strobe, o_Rx_Active returns to 0 within 8 cycles, state=IDLE.
REQ-029 CPB=10, send 0x55 with the stop bit forced low, then hold the line low 30 cycles -> o_Frame_Err pulse once, o_Rx_Byte keeps its previous value, block stays in CLEANUP until the line goes high, then receives the next 0x81 correctly.
REQ-030 Assert i_Reset_n low mid-DATA of 0xFF, release, then send 0x12 -> no strobe for the aborted frame, o_Rx_Byte=0x00 after reset, then 0x12 received.
REQ-031 CPB=0 and CPB=1 -> the block operates as CPB=2; with i_Clocks_per_Bit changed from 10 to 20 mid-frame -> the current byte is still received at CPB=10.
